ttt_board_ctrl: RTL and testbench

Game-state controller that sits directly downstream of the slot counter. It consumes `current_slot` (8 down to 0) and a player "place" pulse, writes the current player's mark into a 9-cell board register, and checks for a win or draw. It then either hands the turn over or ends the game. It drives the counter's `counter_reset` so that the cursor returns to slot 8 at the start of every game and every turn.

---
 rtl/ttt_pkg.sv | 42 ++++
 rtl/ttt_line_check.sv | 24 ++
 rtl/ttt_board_ctrl.sv | 142 ++++++++++++++
 tb/tb_ttt_board_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board controller and any block
// that inspects the board (line checker, future AI/hint logic).
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int BOARD_W   = 2 * NUM_CELLS;
  localparam int NUM_LINES = 8;

  // Two-bit cell encoding; cell i lives at board[2i+1:2i].
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  // Winner codes reported while the game is over.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_PLAY,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Cell indices of the three rows, three columns and two diagonals.
  localparam int WIN_LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Mark belonging to a player (0 = X, 1 = O).
  function automatic logic [1:0] mark_of(input logic player);
    return player ? MARK_O : MARK_X;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Purely combinational detector: is any of the eight lines completely
// filled with the given mark? An EMPTY mark never reports a win.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [1:0]         mark,
  output logic               win
);

  // Scan every line for three cells matching the requested mark.
  always_comb begin
    // NOTE: default assignment first so no path leaves win unassigned (no latch).
    win = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if ((mark != EMPTY) &&
          (board[2*WIN_LINES[l][0] +: 2] == mark) &&
          (board[2*WIN_LINES[l][1] +: 2] == mark) &&
          (board[2*WIN_LINES[l][2] +: 2] == mark))
        win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Game-state controller: writes the mover's mark at the cursor slot, checks
// for a win or draw, hands over the turn, and resets the upstream slot
// counter at the start of every game and every turn.
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter logic START_PLAYER = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         current_slot,
  input  logic               place,
  input  logic               new_game,
  output logic [BOARD_W-1:0] board,
  output logic               turn,
  output logic               counter_reset,
  output logic               move_reject,
  output logic               game_over,
  output logic [1:0]         winner
);

  state_t             state_q;
  logic [BOARD_W-1:0] board_q;
  logic [3:0]         move_cnt_q;
  logic               turn_q;
  logic               counter_reset_q;
  logic               move_reject_q;
  logic               game_over_q;
  logic [1:0]         winner_q;

  logic       slot_free;
  logic [1:0] mover_mark;
  logic       mover_wins;

  assign mover_mark = mark_of(turn_q);

  // Cursor is legal only for slots 0..8 whose cell is still empty.
  always_comb begin
    slot_free = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (current_slot == 4'(i))
        slot_free = (board_q[2*i +: 2] == EMPTY);
    end
  end

  ttt_line_check u_line_check (
    .board (board_q),
    .mark  (mover_mark),
    .win   (mover_wins)
  );

  // Game FSM; every output is a flop so counter_reset is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the board is a plain register that software-visible state
      // depends on, so it is reset along with the control flops.
      state_q         <= ST_CLEAR;
      board_q         <= '0;
      move_cnt_q      <= '0;
      turn_q          <= START_PLAYER;
      winner_q        <= WIN_NONE;
      game_over_q     <= 1'b0;
      move_reject_q   <= 1'b0;
      counter_reset_q <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere; later assignments in this block
      // override the defaults without creating ordering hazards.
      move_reject_q <= 1'b0;
      if (new_game) begin
        state_q         <= ST_CLEAR;
        board_q         <= '0;
        move_cnt_q      <= '0;
        turn_q          <= START_PLAYER;
        winner_q        <= WIN_NONE;
        game_over_q     <= 1'b0;
        counter_reset_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_CLEAR: begin
            board_q         <= '0;
            move_cnt_q      <= '0;
            turn_q          <= START_PLAYER;
            winner_q        <= WIN_NONE;
            game_over_q     <= 1'b0;
            counter_reset_q <= 1'b0;
            state_q         <= ST_PLAY;
          end
          ST_PLAY: begin
            if (place) begin
              if (slot_free) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                  if (current_slot == 4'(i))
                    board_q[2*i +: 2] <= mover_mark;
                end
                if (move_cnt_q < 4'(NUM_CELLS))
                  move_cnt_q <= move_cnt_q + 4'd1;
                state_q <= ST_CHECK;
              end else begin
                move_reject_q <= 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (mover_wins) begin
              winner_q    <= turn_q ? WIN_O : WIN_X;
              game_over_q <= 1'b1;
              state_q     <= ST_DONE;
            end else if (move_cnt_q == 4'(NUM_CELLS)) begin
              winner_q    <= WIN_DRAW;
              game_over_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              turn_q          <= ~turn_q;
              counter_reset_q <= 1'b1;
              state_q         <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            counter_reset_q <= 1'b0;
            state_q         <= ST_PLAY;
          end
          ST_DONE: begin
            if (place)
              move_reject_q <= 1'b1;
          end
          default: begin
            counter_reset_q <= 1'b1;
            state_q         <= ST_CLEAR;
          end
        endcase
      end
    end
  end

  assign board         = board_q;
  assign turn          = turn_q;
  assign counter_reset = counter_reset_q;
  assign move_reject   = move_reject_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed, scoreboard-driven bench for ttt_board_ctrl. Expected outputs are
// queued when stimulus is applied and compared one cycle later, #1 after
// the clock edge.
module tb_ttt_board_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  current_slot;
  logic        place;
  logic        new_game;
  logic [17:0] board;
  logic        turn;
  logic        counter_reset;
  logic        move_reject;
  logic        game_over;
  logic [1:0]  winner;

  ttt_board_ctrl #(.START_PLAYER(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .current_slot  (current_slot),
    .place         (place),
    .new_game      (new_game),
    .board         (board),
    .turn          (turn),
    .counter_reset (counter_reset),
    .move_reject   (move_reject),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model of the externally visible game state.
  logic [17:0] m_board;
  logic        m_turn;
  logic        m_over;
  logic [1:0]  m_win;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_state(input string step, input logic [17:0] b,
                              input logic t, input logic cr, input logic rj,
                              input logic ov, input logic [1:0] w);
    push({step, ".board"},         32'(b));
    push({step, ".turn"},          32'(t));
    push({step, ".counter_reset"}, 32'(cr));
    push({step, ".move_reject"},   32'(rj));
    push({step, ".game_over"},     32'(ov));
    push({step, ".winner"},        32'(w));
  endtask

  task automatic check_state();
    check("board",         32'(board));
    check("turn",          32'(turn));
    check("counter_reset", 32'(counter_reset));
    check("move_reject",   32'(move_reject));
    check("game_over",     32'(game_over));
    check("winner",        32'(winner));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legal move; exp_win = 00 means the game continues.
  task automatic valid_move(input string step, input int slot,
                            input logic [1:0] exp_win);
    m_board[2*slot +: 2] = m_turn ? 2'b10 : 2'b01;
    current_slot = 4'(slot);
    place = 1'b1;
    expect_state({step, "/check"}, m_board, m_turn, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    place = 1'b0;
    check_state();
    if (exp_win == 2'b00) m_turn = ~m_turn;
    else begin
      m_over = 1'b1;
      m_win  = exp_win;
    end
    expect_state({step, "/handover"}, m_board, m_turn, exp_win == 2'b00,
                 1'b0, m_over, m_win);
    tick();
    check_state();
    if (exp_win == 2'b00) begin
      expect_state({step, "/play"}, m_board, m_turn, 1'b0, 1'b0, 1'b0, 2'b00);
      tick();
      check_state();
    end
  endtask

  // Refused move: one-cycle reject pulse, nothing else changes.
  task automatic reject_move(input string step, input logic [3:0] slot);
    current_slot = slot;
    place = 1'b1;
    expect_state({step, "/reject"}, m_board, m_turn, 1'b0, 1'b1, m_over, m_win);
    tick();
    place = 1'b0;
    check_state();
    expect_state({step, "/after"}, m_board, m_turn, 1'b0, 1'b0, m_over, m_win);
    tick();
    check_state();
  endtask

  // new_game pulse, optionally colliding with a place request.
  task automatic start_new_game(input string step, input logic with_place);
    new_game = 1'b1;
    place = with_place;
    current_slot = 4'd3;
    m_board = '0;
    m_turn  = 1'b0;
    m_over  = 1'b0;
    m_win   = 2'b00;
    expect_state({step, "/clear"}, m_board, m_turn, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    new_game = 1'b0;
    place = 1'b0;
    check_state();
    expect_state({step, "/play"}, m_board, m_turn, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    check_state();
  endtask

  initial begin
    reset = 1'b1;
    place = 1'b0;
    new_game = 1'b0;
    current_slot = 4'd8;
    m_board = '0;
    m_turn  = 1'b0;
    m_over  = 1'b0;
    m_win   = 2'b00;

    // Reset, then release: counter_reset held for the first free cycle.
    tick();
    tick();
    expect_state("reset", '0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check_state();
    reset = 1'b0;
    expect_state("release", '0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check_state();
    tick();
    expect_state("first_play", '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_state();

    // X takes 8, O tries 8 as well and is refused.
    valid_move("x8", 8, 2'b00);
    reject_move("o8_occupied", 4'd8);

    // X completes the 0-4-8 diagonal on the fifth legal move.
    valid_move("o7", 7, 2'b00);
    valid_move("x4", 4, 2'b00);
    valid_move("o6", 6, 2'b00);
    valid_move("x0_wins", 0, 2'b01);
    reject_move("done_place", 4'd1);

    // Full board with no line: draw.
    start_new_game("ng1", 1'b0);
    valid_move("d_x8", 8, 2'b00);
    valid_move("d_o4", 4, 2'b00);
    valid_move("d_x7", 7, 2'b00);
    valid_move("d_o6", 6, 2'b00);
    valid_move("d_x2", 2, 2'b00);
    valid_move("d_o5", 5, 2'b00);
    valid_move("d_x3", 3, 2'b00);
    valid_move("d_o1", 1, 2'b00);
    valid_move("d_x0_draw", 0, 2'b11);
    reject_move("draw_place", 4'd4);

    // new_game beats a simultaneous place while in PLAY.
    start_new_game("ng2", 1'b0);
    valid_move("m_x8", 8, 2'b00);
    start_new_game("ng_play", 1'b1);

    // Same collision while the controller sits in CHECK.
    current_slot = 4'd8;
    place = 1'b1;
    m_board[17:16] = 2'b01;
    expect_state("pre_check", m_board, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    place = 1'b0;
    check_state();
    start_new_game("ng_check", 1'b1);

    // Out-of-range cursor is refused and the board is untouched.
    reject_move("slot12", 4'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
